// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding,
// request owner codes and little-endian byte-lane indices.
package dmem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WORD   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_RMW_WR = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DBG = 1'b1;

  localparam logic [1:0] LANE0 = 2'd0;  // bits [7:0]
  localparam logic [1:0] LANE1 = 2'd1;  // bits [15:8]
  localparam logic [1:0] LANE2 = 2'd2;  // bits [23:16]
  localparam logic [1:0] LANE3 = 2'd3;  // bits [31:24]

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational byte-lane helper: extracts and sign-extends the addressed
// byte of a word, and builds the word with that lane replaced by a new byte.
module byte_lane_unit
  import dmem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0] w_lane_byte;

  // Select the addressed lane for loads and splice the new byte in for stores
  always_comb begin
    w_lane_byte = i_word[7:0];
    o_merged    = i_word;
    case (i_lane)
      LANE0: begin w_lane_byte = i_word[7:0];   o_merged[7:0]   = i_byte; end
      LANE1: begin w_lane_byte = i_word[15:8];  o_merged[15:8]  = i_byte; end
      LANE2: begin w_lane_byte = i_word[23:16]; o_merged[23:16] = i_byte; end
      LANE3: begin w_lane_byte = i_word[31:24]; o_merged[31:24] = i_byte; end
    endcase
    o_load = {{24{w_lane_byte[7]}}, w_lane_byte};
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU and debug ports.
// Handshake: a requester raises req with fields stable and holds them until
// its ack; ack is a one-cycle pulse with rdata valid in that same cycle, and
// the requester must drop req (or present a new request) the cycle after.
// A request is only sampled in IDLE, so a non-owner req simply waits.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int MEM_AW     = 6,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_byte,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_ack,
  output logic [31:0]       cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic              dbg_byte,
  input  logic [31:0]       dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_ack,
  output logic [31:0]       dbg_rdata,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_a,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd,
  output state_t            fsm_state
);

  localparam int CW = $clog2(STARVE_MAX + 2);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  state_t            r_state, w_next;
  logic              r_owner, r_we, r_byte;
  logic [MEM_AW+1:0] r_addr;
  logic [31:0]       r_wdata, r_merge, r_cpu_rdata, r_dbg_rdata;
  logic [CW-1:0]     r_starve;

  logic              w_grant, w_pick_dbg, w_sel_we, w_sel_byte, w_mem_we;
  logic [MEM_AW+1:0] w_sel_addr;
  logic [31:0]       w_sel_wdata, w_lane_load, w_lane_merged, w_load_data;
  logic              w_unused_addr_bits;

  // Address bits above the memory window are deliberately dropped (wrap).
  assign w_unused_addr_bits = ^{cpu_addr[31:MEM_AW+2], dbg_addr[31:MEM_AW+2]};

  byte_lane_unit u_lane (
    .i_word   (mem_rd),
    .i_lane   (r_addr[1:0]),
    .i_byte   (r_wdata[7:0]),
    .o_load   (w_lane_load),
    .o_merged (w_lane_merged)
  );

  // Arbitration: CPU by default, debug when alone or when it has starved long enough
  always_comb begin
    w_grant     = cpu_req | dbg_req;
    w_pick_dbg  = dbg_req & (~cpu_req | (r_starve == STARVE_LIM));
    w_sel_we    = w_pick_dbg ? dbg_we    : cpu_we;
    w_sel_byte  = w_pick_dbg ? dbg_byte  : cpu_byte;
    w_sel_addr  = w_pick_dbg ? dbg_addr[MEM_AW+1:0] : cpu_addr[MEM_AW+1:0];
    w_sel_wdata = w_pick_dbg ? dbg_wdata : cpu_wdata;
    w_load_data = r_we ? 32'd0 : (r_byte ? w_lane_load : mem_rd);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and write-enable decode
  always_comb begin
    w_next   = r_state;
    w_mem_we = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) w_next = (w_sel_byte && w_sel_we) ? ST_RMW_RD : ST_WORD;
      end
      ST_WORD: begin
        w_mem_we = r_we;
        w_next   = ST_RESP;
      end
      ST_RMW_RD: w_next = ST_RMW_WR;
      ST_RMW_WR: begin
        w_mem_we = 1'b1;
        w_next   = ST_RESP;
      end
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Request latch, starvation counter, merge buffer and per-port read data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner     <= OWNER_CPU;
      r_we        <= 1'b0;
      r_byte      <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_merge     <= '0;
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
      r_starve    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_owner <= w_pick_dbg ? OWNER_DBG : OWNER_CPU;
            r_we    <= w_sel_we;
            r_byte  <= w_sel_byte;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            if (w_pick_dbg)   r_starve <= '0;
            else if (dbg_req) r_starve <= r_starve + CW'(1);
          end
        end
        ST_WORD: begin
          if (r_owner == OWNER_DBG) r_dbg_rdata <= w_load_data;
          else                      r_cpu_rdata <= w_load_data;
        end
        ST_RMW_RD: begin
          r_merge <= w_lane_merged;
          if (r_owner == OWNER_DBG) r_dbg_rdata <= '0;
          else                      r_cpu_rdata <= '0;
        end
        default: ;
      endcase
    end
  end

  assign cpu_ack   = (r_state == ST_RESP) && (r_owner == OWNER_CPU);
  assign dbg_ack   = (r_state == ST_RESP) && (r_owner == OWNER_DBG);
  assign cpu_rdata = r_cpu_rdata;
  assign dbg_rdata = r_dbg_rdata;
  assign mem_we    = w_mem_we;
  assign mem_a     = r_addr[MEM_AW+1:2];
  assign mem_wd    = (r_state == ST_RMW_WR) ? r_merge : r_wdata;
  assign fsm_state = r_state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic checked
// against a word-array reference model of the memory.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int MEM_AW     = 6;
  localparam int STARVE_MAX = 4;
  localparam int NWORDS     = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_req, cpu_we, cpu_byte;
  logic [31:0]       cpu_addr, cpu_wdata, cpu_rdata;
  logic              cpu_ack;
  logic              dbg_req, dbg_we, dbg_byte;
  logic [31:0]       dbg_addr, dbg_wdata, dbg_rdata;
  logic              dbg_ack;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_a;
  logic [31:0]       mem_wd, mem_rd;
  state_t            fsm_state;

  // Memory device and the reference image of its expected contents
  logic [31:0]       mem_arr [NWORDS];
  logic [31:0]       ref_mem [NWORDS];
  logic              init_en;
  logic [MEM_AW-1:0] init_idx;
  logic [31:0]       init_val;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  dmem_arbiter #(.MEM_AW(MEM_AW), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_byte(cpu_byte), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_byte(dbg_byte), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset / memory ----------------
  always #5 clk = ~clk;

  assign mem_rd = mem_arr[mem_a];

  always @(posedge clk) begin
    if (mem_we)       mem_arr[mem_a]   <= mem_wd;
    else if (init_en) mem_arr[init_idx] <= init_val;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Applies one operation to ref_mem and returns what the DUT must show.
  function automatic void model_op(input bit we, input bit byt, input logic [31:0] addr,
                                   input logic [31:0] wdata, output logic [31:0] e_rd,
                                   output int e_lat, output int e_nwr, output int e_idx);
    int unsigned sh;
    logic [31:0] b;
    e_idx = int'((addr / 4) % NWORDS);
    sh    = 8 * (addr % 4);
    e_rd  = 32'd0;
    if (we) begin
      e_nwr = 1;
      if (byt) begin
        ref_mem[e_idx] = (ref_mem[e_idx] & ~(32'hFF << sh)) | ((wdata & 32'hFF) << sh);
        e_lat = 4;
      end else begin
        ref_mem[e_idx] = wdata;
        e_lat = 3;
      end
    end else begin
      e_nwr = 0;
      e_lat = 3;
      if (byt) begin
        b    = (ref_mem[e_idx] >> sh) & 32'hFF;
        e_rd = (b > 127) ? (b | 32'hFFFF_FF00) : b;
      end else begin
        e_rd = ref_mem[e_idx];
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic init_memory();
    for (int i = 0; i < NWORDS; i++) begin
      @(negedge clk);
      init_idx   = MEM_AW'(i);
      init_val   = $urandom;
      ref_mem[i] = init_val;
      init_en    = 1'b1;
    end
    @(negedge clk);
    init_en = 1'b0;
  endtask

  // Issues one request on a port from IDLE and watches it to completion.
  // Latency counts the IDLE sampling cycle as cycle 1.
  task automatic do_op(input bit port, input bit we, input bit byt, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rd, output int lat,
                       output int nwr, output logic [MEM_AW-1:0] wa, output logic [MEM_AW-1:0] a0,
                       output bit other_ack, output bit timeout);
    rd = '0; lat = 0; nwr = 0; wa = '0; a0 = '0; other_ack = 1'b0; timeout = 1'b1;
    if (port) begin
      dbg_req = 1'b1; dbg_we = we; dbg_byte = byt; dbg_addr = addr; dbg_wdata = wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_byte = byt; cpu_addr = addr; cpu_wdata = wdata;
    end
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 1) a0 = mem_a;
      if (mem_we) begin nwr++; wa = mem_a; end
      if (port ? cpu_ack : dbg_ack) other_ack = 1'b1;
      if (port ? dbg_ack : cpu_ack) begin
        rd = port ? dbg_rdata : cpu_rdata;
        lat = n + 1;
        timeout = 1'b0;
        break;
      end
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_cmp++; if (fsm_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", fsm_state, ST_IDLE); end
    n_cmp++; if ({cpu_ack, dbg_ack, mem_we} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 000", {cpu_ack, dbg_ack, mem_we}); end
    n_cmp++; if (mem_a !== '0) begin n_fail++; $display("FAIL reset_mem_a: got %h expected 0", mem_a); end
    n_cmp++; if (mem_wd !== 32'd0) begin n_fail++; $display("FAIL reset_mem_wd: got %h expected 0", mem_wd); end
    n_cmp++; if ({cpu_rdata, dbg_rdata} !== 64'd0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", {cpu_rdata, dbg_rdata}); end
  endtask

  // Runs a list of CPU/debug operations with full per-op checking.
  task automatic test_ops(input string tag, input int n, input bit rnd);
    bit port, we, byt, oth, to;
    logic [31:0] addr, wdata, rd, e_rd;
    logic [MEM_AW-1:0] wa, a0;
    int lat, nwr, e_lat, e_nwr, e_idx;
    for (int k = 0; k < n; k++) begin
      if (rnd) begin
        port = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
        byt = 1'($urandom_range(0, 1)); addr = $urandom; wdata = $urandom;
      end else begin
        port = 1'b0; we = exp_q.pop_front() != 0; byt = exp_q.pop_front() != 0;
        addr = exp_q.pop_front(); wdata = exp_q.pop_front();
      end
      model_op(we, byt, addr, wdata, e_rd, e_lat, e_nwr, e_idx);
      do_op(port, we, byt, addr, wdata, rd, lat, nwr, wa, a0, oth, to);
      n_cmp++; if (to) begin n_fail++; $display("FAIL %s_timeout op%0d: no ack within bound", tag, k); end
      n_cmp++; if (rd !== e_rd) begin n_fail++; $display("FAIL %s_rdata op%0d: got %h expected %h", tag, k, rd, e_rd); end
      n_cmp++; if (lat != e_lat) begin n_fail++; $display("FAIL %s_latency op%0d: got %0d expected %0d", tag, k, lat, e_lat); end
      n_cmp++; if (nwr != e_nwr) begin n_fail++; $display("FAIL %s_writes op%0d: got %0d expected %0d", tag, k, nwr, e_nwr); end
      n_cmp++; if (a0 !== MEM_AW'(e_idx)) begin n_fail++; $display("FAIL %s_mem_a op%0d: got %0d expected %0d", tag, k, a0, e_idx); end
      if (e_nwr == 1) begin
        n_cmp++; if (wa !== MEM_AW'(e_idx)) begin n_fail++; $display("FAIL %s_wr_addr op%0d: got %0d expected %0d", tag, k, wa, e_idx); end
      end
      n_cmp++; if (oth) begin n_fail++; $display("FAIL %s_wrong_ack op%0d: got 1 expected 0", tag, k); end
    end
  endtask

  task automatic test_word_store_load();
    exp_q = '{32'd1, 32'd0, 32'h10, 32'hDEADBEEF,
              32'd0, 32'd0, 32'h10, 32'h0};
    test_ops("word", 2, 1'b0);
    n_cmp++; if (mem_arr[4] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL word_mem4: got %h expected deadbeef", mem_arr[4]); end
  endtask

  task automatic test_byte_rmw();
    exp_q = '{32'd1, 32'd0, 32'h20, 32'h11223344,
              32'd1, 32'd1, 32'h22, 32'hFFFF_FFAA};
    test_ops("sb", 2, 1'b0);
    n_cmp++; if (mem_arr[8] !== 32'h11AA3344) begin n_fail++; $display("FAIL sb_mem8: got %h expected 11aa3344", mem_arr[8]); end
  endtask

  task automatic test_byte_load();
    logic [31:0] rd, e_rd;
    logic [MEM_AW-1:0] wa, a0;
    int lat, nwr, e_lat, e_nwr, e_idx;
    bit oth, to;
    model_op(1'b0, 1'b1, 32'h22, 32'h0, e_rd, e_lat, e_nwr, e_idx);
    do_op(1'b0, 1'b0, 1'b1, 32'h22, 32'h0, rd, lat, nwr, wa, a0, oth, to);
    n_cmp++; if (rd !== 32'hFFFF_FFAA) begin n_fail++; $display("FAIL lb_neg: got %h expected ffffffaa", rd); end
    model_op(1'b0, 1'b1, 32'h20, 32'h0, e_rd, e_lat, e_nwr, e_idx);
    do_op(1'b1, 1'b0, 1'b1, 32'h20, 32'h0, rd, lat, nwr, wa, a0, oth, to);
    n_cmp++; if (rd !== 32'h0000_0044) begin n_fail++; $display("FAIL lb_pos_dbg: got %h expected 00000044", rd); end
    n_cmp++; if (lat != 3) begin n_fail++; $display("FAIL lb_latency: got %0d expected 3", lat); end
    exp_q = '{32'd0, 32'd1, 32'h23, 32'h0, 32'd0, 32'd1, 32'h21, 32'h0};
    test_ops("lb", 2, 1'b0);
  endtask

  task automatic test_addr_wrap();
    exp_q = '{32'd1, 32'd0, 32'h0,   32'h5A5A_1234,
              32'd0, 32'd0, 32'h100, 32'h0,
              32'd1, 32'd1, 32'hFFFF_FFFF, 32'h77,
              32'd0, 32'd0, 32'hFC, 32'h0};
    test_ops("wrap", 4, 1'b0);
  endtask

  task automatic test_starvation();
    int cnt = 0;
    int done = 0;
    logic [31:0] e;
    exp_q.delete();
    for (int k = 0; k < 10; k++) begin
      if (cnt == STARVE_MAX) begin exp_q.push_back(32'd1); cnt = 0; end
      else begin exp_q.push_back(32'd0); cnt++; end
    end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_byte = 1'b0; cpu_addr = 32'h40; cpu_wdata = '0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_byte = 1'b0; dbg_addr = 32'h84; dbg_wdata = '0;
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) begin
      @(posedge clk);
      @(negedge clk);
      n_cmp++; if (cpu_ack && dbg_ack) begin n_fail++; $display("FAIL starve_both_ack: got 1 expected 0"); end
      if (cpu_ack || dbg_ack) begin
        e = exp_q.pop_front();
        done++;
        n_cmp++; if ({31'd0, dbg_ack} !== e) begin n_fail++; $display("FAIL starve_order grant%0d: got dbg=%0d expected dbg=%0d", done, dbg_ack, e); end
        n_cmp++; if ((dbg_ack ? dbg_rdata : cpu_rdata) !== (dbg_ack ? ref_mem[33] : ref_mem[16])) begin
          n_fail++; $display("FAIL starve_rdata grant%0d: got %h expected %h", done,
                             dbg_ack ? dbg_rdata : cpu_rdata, dbg_ack ? ref_mem[33] : ref_mem[16]);
        end
        if (exp_q.size() == 0) begin cpu_req = 1'b0; dbg_req = 1'b0; end
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL starve_timeout: got %0d grants expected 10", done); end
    cpu_req = 1'b0; dbg_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_rmw();
    exp_q = '{32'd1, 32'd0, 32'h30, 32'hCAFE_F00D};
    test_ops("rst_pre", 1, 1'b0);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_byte = 1'b1; cpu_addr = 32'h31; cpu_wdata = 32'h55;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (fsm_state !== ST_RMW_RD) begin n_fail++; $display("FAIL rst_in_rmw_rd: got %0d expected %0d", fsm_state, ST_RMW_RD); end
    reset = 1'b1;
    #1;
    n_cmp++; if (fsm_state !== ST_IDLE) begin n_fail++; $display("FAIL rst_async_state: got %0d expected %0d", fsm_state, ST_IDLE); end
    cpu_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({mem_we, cpu_ack, dbg_ack} !== 3'b000) begin n_fail++; $display("FAIL rst_no_side: got %b expected 000", {mem_we, cpu_ack, dbg_ack}); end
    n_cmp++; if (mem_arr[12] !== ref_mem[12]) begin n_fail++; $display("FAIL rst_mem_kept: got %h expected %h", mem_arr[12], ref_mem[12]); end
    reset = 1'b0;
    @(negedge clk);
    exp_q = '{32'd1, 32'd1, 32'h31, 32'h55, 32'd0, 32'd0, 32'h30, 32'h0};
    test_ops("rst_post", 2, 1'b0);
  endtask

  task automatic test_random();
    test_ops("rand", 40, 1'b1);
    for (int i = 0; i < NWORDS; i++) begin
      n_cmp++; if (mem_arr[i] !== ref_mem[i]) begin n_fail++; $display("FAIL rand_mem word%0d: got %h expected %h", i, mem_arr[i], ref_mem[i]); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1; init_en = 1'b0; init_idx = '0; init_val = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_byte = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_byte = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    init_memory();
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_word_store_load();
    test_byte_rmw();
    test_byte_load();
    test_addr_wrap();
    test_starvation();
    test_reset_mid_rmw();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
